// File: rtl/seg_scan_if.sv
// Load handshake between a display-value producer and seg_scan_ctrl.
// The producer drives the master side; the scan controller is the slave.
interface seg_scan_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic        load_blank_lz;

  modport master (output load_valid, load_value, load_blank_lz, input load_ready);
  modport slave  (input load_valid, load_value, load_blank_lz, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler: walks the digits through a shared decoder,
// blanks the anodes at the start of each slot, and swaps display values only at frame ends.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  load,
  output logic [3:0] number,
  output logic [3:0] anode,
  output logic       frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] C_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] C_PRE   = CW'(REFRESH_DIV - 2);
  localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);

  typedef enum logic {BLANK, SHOW} phase_t;

  logic [CW-1:0] c_q, c_n;
  logic [1:0]    d_q, d_n;
  phase_t        phase_q, phase_n;
  logic [15:0]   act_val_q, act_val_n;
  logic          act_lz_q, act_lz_n;
  logic [15:0]   pend_val_q;
  logic          pend_lz_q;
  logic          pend_q, pend_n;
  logic [3:0]    number_n, anode_n;
  logic          frame_done_n;
  logic          xfer, slot_end, frame_end;

  // A leading digit goes dark when it and every digit above it are zero; digit 0 always shows.
  function automatic logic [3:0] digit_code(input logic [15:0] val, input logic lz,
                                            input logic [1:0] idx);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < 4; i++)
      if (i >= int'(idx) && val[i*4 +: 4] != 4'h0) upper_zero = 1'b0;
    if (lz && idx != 2'd0 && upper_zero) return 4'hF;
    return val[int'(idx)*4 +: 4];
  endfunction

  assign load.load_ready = ~pend_q;

  always_comb begin
    xfer         = load.load_valid & ~pend_q;
    slot_end     = (c_q == C_LAST);
    frame_end    = slot_end && (d_q == 2'd3);
    c_n          = slot_end ? '0 : c_q + 1'b1;
    d_n          = slot_end ? d_q + 2'd1 : d_q;
    phase_n      = (c_n < C_BLANK) ? BLANK : SHOW;
    act_val_n    = act_val_q;
    act_lz_n     = act_lz_q;
    pend_n       = pend_q;
    if (pend_q) begin
      if (frame_end) begin
        act_val_n = pend_val_q;
        act_lz_n  = pend_lz_q;
        pend_n    = 1'b0;
      end
    end else if (xfer) begin
      pend_n = 1'b1;
    end
    number_n     = (c_q == '0) ? digit_code(act_val_q, act_lz_q, d_q) : number;
    anode_n      = (phase_q == SHOW) ? ~(4'b0001 << d_q) : 4'b1111;
    // Registered one cycle early so the pulse lands on the frame's last cycle.
    frame_done_n = (c_q == C_PRE) && (d_q == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q        <= '0;
      d_q        <= 2'd0;
      phase_q    <= BLANK;
      act_val_q  <= 16'h0000;
      act_lz_q   <= 1'b0;
      pend_q     <= 1'b0;
      number     <= 4'hF;
      anode      <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      c_q        <= c_n;
      d_q        <= d_n;
      phase_q    <= phase_n;
      act_val_q  <= act_val_n;
      act_lz_q   <= act_lz_n;
      pend_q     <= pend_n;
      number     <= number_n;
      anode      <= anode_n;
      frame_done <= frame_done_n;
    end
  end

  // Pending payload is qualified by pend_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      pend_val_q <= load.load_value;
      pend_lz_q  <= load.load_blank_lz;
    end
  end
endmodule
